// File: rtl/countdown_scheduler_pkg.sv
// Shared types and defaults for the countdown scheduler and its round-robin arbiter.
// State encoding is fixed at 2 bits: IDLE=0, LOAD=1, COUNT=2, DONE=3.
package countdown_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/countdown_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter
    import countdown_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!valid && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_scheduler.sv
// Shares one external down-counter among NREQ requesters, granting them round-robin
// and driving latch/dec until the counter reports zero.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no owner; arbitrate on req, capture owner index and value
//   S_LOAD  | latch captured value into the counter, grant asserted
//   S_COUNT | decrement while !cnt_zero; zero -> DONE, req[owner] low -> IDLE
//   S_DONE  | one-cycle done pulse to owner, pointer moves past owner
module countdown_scheduler
    import countdown_scheduler_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   load_val,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [WIDTH-1:0]        cnt_in,
    output logic                    cnt_latch,
    output logic                    cnt_dec,
    input  logic                    cnt_zero
);

    localparam int PW = ptr_width(NREQ);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_owner;
    logic [PW-1:0]     r_ptr;
    logic [WIDTH-1:0]  r_val;

    logic [NREQ-1:0]   w_winner;
    logic              w_valid;
    logic [PW-1:0]     w_win_idx;
    logic [WIDTH-1:0]  w_win_val;
    logic [NREQ-1:0]   w_owner_oh;
    logic [PW-1:0]     w_ptr_nxt;
    logic              w_abort;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_comb begin
        w_win_idx = '0;
        w_win_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PW'(i);
                w_win_val = load_val[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_ptr_nxt  = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
    // Zero wins over abort, so an abort is only a non-zero COUNT cycle with req dropped.
    assign w_abort    = (r_state == S_COUNT) && !cnt_zero && !req[r_owner];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_COUNT;
            S_COUNT: begin
                if (cnt_zero) begin
                    w_state_nxt = S_DONE;
                end else if (!req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_val   <= '0;
        end else begin
            if (r_state == S_IDLE && w_valid) begin
                r_owner <= w_win_idx;
                r_val   <= w_win_val;
            end
            if (r_state == S_DONE || w_abort) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign gnt       = busy ? w_owner_oh : '0;
    assign done      = (r_state == S_DONE) ? w_owner_oh : '0;
    assign cnt_latch = (r_state == S_LOAD);
    assign cnt_dec   = (r_state == S_COUNT) && !cnt_zero;
    assign cnt_in    = busy ? r_val : '0;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed + randomized bench for countdown_scheduler with a behavioural down-counter
// and a round-robin / latency reference model.
module tb_countdown_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] load_val;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt_in;
    logic        cnt_latch;
    logic        cnt_dec;
    logic        cnt_zero;

    logic [3:0]  cnt_q = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ptr   = 0;

    countdown_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .load_val  (load_val),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt_in    (cnt_in),
        .cnt_latch (cnt_latch),
        .cnt_dec   (cnt_dec),
        .cnt_zero  (cnt_zero)
    );

    always #5 clock = ~clock;

    // Shared down-counter: latch loads, dec subtracts one, zero is combinational.
    always @(posedge clock) begin
        if (cnt_latch)    cnt_q <= cnt_in;
        else if (cnt_dec) cnt_q <= cnt_q - 4'd1;
    end
    assign cnt_zero = (cnt_q == 4'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] rq);
        for (int k = 0; k < 4; k++) begin
            if (rq[(tb_ptr + k) % 4]) return (tb_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int w);
        logic [3:0] one;
        one = 4'b0001;
        return one << w;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        req = 4'b0; load_val = 16'h0;
        @(negedge clock);
        @(negedge clock);
        check("rst_gnt",  gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_cin",  cnt_in, 0);
        reset_n = 1'b1;
        tb_ptr = 0;
    endtask

    // Called at a negedge with the DUT idle; runs one complete grant..done sequence.
    task automatic do_txn(input logic [3:0] rq, input logic [15:0] lv, input bit glitch);
        int w, v, k, n_dec;
        bit seen;
        w = model_pick(rq);
        v = int'(lv[w*4 +: 4]);
        req = rq;
        load_val = lv;
        @(negedge clock);
        check("grant", gnt, onehot(w));
        check("load_latch", cnt_latch, 1);
        check("load_cin", cnt_in, v);
        load_val = 16'($urandom);
        if (glitch) req[w] = 1'b0;
        @(posedge clock);
        #1 req = rq;
        n_dec = 0; k = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clock);
            k++;
            n_dec += int'(cnt_dec);
            if (done != 4'b0) seen = 1;
            else check("busy_counting", busy, 1);
        end
        check("done_seen", seen, 1);
        check("done_time", k, v + 2);
        check("done_owner", done, onehot(w));
        check("gnt_held", gnt, onehot(w));
        check("dec_cycles", n_dec, v);
        check("cnt_final", cnt_q, 0);
        @(negedge clock);
        check("idle_gnt", gnt, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_cin", cnt_in, 0);
        tb_ptr = (w + 1) % 4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req = 4'b0;
        load_val = 16'h0;
        apply_reset();

        // basic countdown of 2, then zero-length countdown
        do_txn(4'b0001, 16'h0002, 0);
        do_txn(4'b0001, 16'h0000, 0);

        // two requesters: 0 first, then 2 once 0 drops
        apply_reset();
        do_txn(4'b0101, 16'h0304, 0);
        do_txn(4'b0100, 16'h0304, 0);

        // all four held with value 1: full rotation and back to 0
        apply_reset();
        for (int i = 0; i < 5; i++) do_txn(4'b1111, 16'h1111, 0);

        // maximum value
        do_txn(4'b0010, 16'h00F0, 0);

        // abort requester 1 after five decrements of 15
        begin
            bit any_done;
            req = 4'b0010;
            load_val = 16'h00F0;
            @(negedge clock);
            check("abort_grant", gnt, 4'b0010);
            for (int i = 1; i <= 5; i++) begin
                @(negedge clock);
                check("abort_dec", cnt_dec, 1);
            end
            req = 4'b0000;
            @(negedge clock);
            check("abort_busy", busy, 0);
            check("abort_gnt", gnt, 0);
            check("abort_cnt", cnt_q, 10);
            any_done = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                if (done != 4'b0) any_done = 1;
            end
            check("abort_no_done", any_done, 0);
            tb_ptr = 2;
            do_txn(4'b0100, 16'h0300, 0);
        end

        // async reset mid-COUNT
        req = 4'b1000;
        load_val = 16'h9000;
        @(negedge clock);
        check("mid_grant", gnt, 4'b1000);
        repeat (3) @(negedge clock);
        check("mid_dec", cnt_dec, 1);
        reset_n = 1'b0;
        #1;
        check("arst_out", {gnt, done, busy, cnt_latch, cnt_dec, cnt_in}, 0);
        req = 4'b0011;
        @(negedge clock);
        reset_n = 1'b1;
        tb_ptr = 0;
        do_txn(4'b0011, 16'h0021, 0);

        // randomized traffic, some with req glitched low during LOAD
        for (int i = 0; i < 24; i++) begin
            do_txn(4'($urandom_range(1, 15)), 16'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
